fractal_sync_initiator: RTL and testbench



---
 rtl/fractal_sync_initiator.sv | 166 ++++++++++++++++
 tb/tb_fractal_sync_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_initiator.sv
// Leaf-side initiator of the fractal sync tree: issues sync requests and matches wake responses.
// Per-entry expiry is compiled in when FRACTAL_SYNC_INITIATOR_TIMEOUT_EN is defined.
module fractal_sync_initiator #(
  parameter int AGGREGATE_WIDTH = 1,
  parameter int ID_WIDTH = 1,
  parameter int SD_WIDTH = 2,
  parameter logic [SD_WIDTH-1:0] SRC_DIR = 2'b01,
  parameter int OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bar_valid_i,
  output logic                       bar_ready_o,
  input  logic [AGGREGATE_WIDTH-1:0] bar_aggr_i,
  input  logic [ID_WIDTH-1:0]        bar_id_i,
  output logic                       done_o,
  output logic [AGGREGATE_WIDTH-1:0] done_aggr_o,
  output logic [ID_WIDTH-1:0]        done_id_o,
  output logic                       done_error_o,
  output logic                       done_timeout_o,
  output logic                       busy_o,
  output logic                       req_sync_o,
  output logic [AGGREGATE_WIDTH-1:0] req_aggr_o,
  output logic [ID_WIDTH-1:0]        req_id_o,
  output logic [SD_WIDTH-1:0]        req_src_o,
  input  logic                       rsp_wake_i,
  input  logic [AGGREGATE_WIDTH-1:0] rsp_aggr_i,
  input  logic [ID_WIDTH-1:0]        rsp_id_i,
  input  logic                       rsp_error_i,
  output logic                       unexpected_o
);

  logic [OUTSTANDING-1:0]     ent_valid, ent_cmpl, ent_err, ent_exp;
  logic [AGGREGATE_WIDTH-1:0] ent_aggr [OUTSTANDING];
  logic [ID_WIDTH-1:0]        ent_id   [OUTSTANDING];

  logic                       req_valid_q;
  logic [AGGREGATE_WIDTH-1:0] req_aggr_q;
  logic [ID_WIDTH-1:0]        req_id_q;
  logic                       unexpected_q;

  logic                   full, dup, accept;
  logic [OUTSTANDING-1:0] alloc_oh, fin, done_oh, rsp_hit, wake_take;

  always_comb begin
    dup     = 1'b0;
    rsp_hit = '0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (ent_valid[i] && ent_aggr[i] == bar_aggr_i && ent_id[i] == bar_id_i) dup = 1'b1;
      rsp_hit[i] = ent_valid[i] && ent_aggr[i] == rsp_aggr_i && ent_id[i] == rsp_id_i;
    end
  end

  // Barrier handshake: a request transfers on a rising edge where bar_valid_i && bar_ready_o;
  // ready never depends on valid, and a stalled requester must hold aggr/id stable.
  assign full        = &ent_valid;
  assign bar_ready_o = !rst_i && !full && !dup && !req_valid_q;
  assign accept      = bar_valid_i && bar_ready_o;

  // Lowest free slot and lowest finished slot, each as a one-hot vector.
  assign alloc_oh  = ~ent_valid & (ent_valid + OUTSTANDING'(1));
  assign fin       = ent_cmpl | ent_exp;
  assign done_oh   = fin & (~fin + OUTSTANDING'(1));
  assign wake_take = {OUTSTANDING{rsp_wake_i}} & rsp_hit & ~ent_cmpl & ~ent_exp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_valid <= '0;
      ent_cmpl  <= '0;
      ent_err   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_aggr[i] <= '0;
        ent_id[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (accept && alloc_oh[i]) begin
          ent_valid[i] <= 1'b1;
          ent_cmpl[i]  <= 1'b0;
          ent_err[i]   <= 1'b0;
          ent_aggr[i]  <= bar_aggr_i;
          ent_id[i]    <= bar_id_i;
        end else if (done_oh[i]) begin
          ent_valid[i] <= 1'b0;
          ent_cmpl[i]  <= 1'b0;
          ent_err[i]   <= 1'b0;
        end else if (wake_take[i]) begin
          ent_cmpl[i] <= 1'b1;
          ent_err[i]  <= rsp_error_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q  <= 1'b0;
      req_aggr_q   <= '0;
      req_id_q     <= '0;
      unexpected_q <= 1'b0;
    end else begin
      req_valid_q <= accept;
      req_aggr_q  <= accept ? bar_aggr_i : '0;
      req_id_q    <= accept ? bar_id_i : '0;
      if (rsp_wake_i && rsp_hit == '0) unexpected_q <= 1'b1;
    end
  end

`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0]       ent_cnt [OUTSTANDING];
  logic [OUTSTANDING-1:0] ent_exp_q;

  // A wake at the same edge as the last count wins, so the counter only runs while nothing is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent_exp_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) ent_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (accept && alloc_oh[i]) begin
          ent_cnt[i]   <= '0;
          ent_exp_q[i] <= 1'b0;
        end else if (done_oh[i]) begin
          ent_exp_q[i] <= 1'b0;
        end else if (ent_valid[i] && !ent_cmpl[i] && !ent_exp_q[i] && !wake_take[i]) begin
          if (ent_cnt[i] == CNT_W'(TIMEOUT_CYCLES - 1)) ent_exp_q[i] <= 1'b1;
          else ent_cnt[i] <= ent_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ent_exp = ent_exp_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign ent_exp        = '0;
`endif

  always_comb begin
    done_aggr_o    = '0;
    done_id_o      = '0;
    done_error_o   = 1'b0;
    done_timeout_o = 1'b0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (done_oh[i]) begin
        done_aggr_o    = ent_aggr[i];
        done_id_o      = ent_id[i];
        done_error_o   = ent_err[i] | ent_exp[i];
        done_timeout_o = ent_exp[i];
      end
    end
  end

  assign done_o       = |fin;
  assign busy_o       = |ent_valid;
  assign req_sync_o   = req_valid_q;
  assign req_aggr_o   = req_aggr_q;
  assign req_id_o     = req_id_q;
  assign req_src_o    = req_valid_q ? SRC_DIR : '0;
  assign unexpected_o = unexpected_q;

endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Self-checking bench for fractal_sync_initiator: directed scenarios plus random traffic
// compared each cycle against a table-level reference model.
module tb_fractal_sync_initiator;
  localparam int AW  = 1;
  localparam int IW  = 2;
  localparam int SW  = 2;
  localparam int OUT = 2;
  localparam int TO  = 8;
  localparam logic [SW-1:0] SRC = 2'b01;
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  // Scenario 1 wakes before the short expiry window when expiry is compiled in.
  localparam int WAKE_AT = TO_EN ? 6 : 10;

  localparam int ST_PEND = 0;
  localparam int ST_DONE = 1;
  localparam int ST_EXP  = 2;

  logic          clk, rst;
  logic          bar_valid, bar_ready;
  logic [AW-1:0] bar_aggr;
  logic [IW-1:0] bar_id;
  logic          done, done_error, done_timeout, busy, req_sync, unexpected;
  logic [AW-1:0] done_aggr, req_aggr, rsp_aggr;
  logic [IW-1:0] done_id, req_id, rsp_id;
  logic [SW-1:0] req_src;
  logic          rsp_wake, rsp_error;

  fractal_sync_initiator #(
    .AGGREGATE_WIDTH(AW), .ID_WIDTH(IW), .SD_WIDTH(SW), .SRC_DIR(SRC),
    .OUTSTANDING(OUT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .bar_valid_i(bar_valid), .bar_ready_o(bar_ready), .bar_aggr_i(bar_aggr), .bar_id_i(bar_id),
    .done_o(done), .done_aggr_o(done_aggr), .done_id_o(done_id),
    .done_error_o(done_error), .done_timeout_o(done_timeout), .busy_o(busy),
    .req_sync_o(req_sync), .req_aggr_o(req_aggr), .req_id_o(req_id), .req_src_o(req_src),
    .rsp_wake_i(rsp_wake), .rsp_aggr_i(rsp_aggr), .rsp_id_i(rsp_id), .rsp_error_i(rsp_error),
    .unexpected_o(unexpected)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: pending barriers as records, sync pulses as a queue of {aggr,id}.
  typedef struct {
    bit          v;
    bit [AW-1:0] aggr;
    bit [IW-1:0] id;
    int          st;
    bit          err;
    int          acc;
  } ent_t;

  ent_t m [OUT];
  logic [AW+IW-1:0] exp_q[$];
  bit m_unexp = 1'b0;
  int edge_n  = 0;

  function automatic int m_done_idx();
    for (int i = 0; i < OUT; i++) if (m[i].v && m[i].st != ST_PEND) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    bit full, dup;
    full = 1'b1;
    dup  = 1'b0;
    if (rst) return 1'b0;
    for (int i = 0; i < OUT; i++) begin
      if (!m[i].v) full = 1'b0;
      if (m[i].v && m[i].aggr == bar_aggr && m[i].id == bar_id) dup = 1'b1;
    end
    return !full && !dup && exp_q.size() == 0;
  endfunction

  // One clock: compare outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int di;
    bit rdy, acc, hit, placed;
    ent_t nxt [OUT];
    logic [AW+IW-1:0] rq;
    logic [AW+IW+1:0] want_done;
    @(negedge clk);
    di  = m_done_idx();
    rdy = m_ready();
    check("bar_ready", 32'(bar_ready), 32'(rdy));
    check("req_sync", 32'(req_sync), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      rq = exp_q.pop_front();
      check("req_fields", 32'({req_src, req_aggr, req_id}), 32'({SRC, rq}));
    end
    check("done", 32'(done), 32'(di >= 0));
    if (di >= 0) begin
      want_done = {m[di].st == ST_EXP, m[di].err || m[di].st == ST_EXP, m[di].aggr, m[di].id};
      check("done_fields", 32'({done_timeout, done_error, done_aggr, done_id}), 32'(want_done));
    end
    check("busy", 32'(busy), 32'(m[0].v || m[OUT-1].v));
    check("unexpected", 32'(unexpected), 32'(m_unexp));

    acc = rdy && bar_valid;
    if (rst) begin
      for (int i = 0; i < OUT; i++) m[i] = '{default: 0};
      exp_q.delete();
      m_unexp = 1'b0;
    end else begin
      nxt = m;
      if (rsp_wake) begin
        hit = 1'b0;
        for (int i = 0; i < OUT; i++) begin
          if (m[i].v && m[i].aggr == rsp_aggr && m[i].id == rsp_id) begin
            hit = 1'b1;
            if (m[i].st == ST_PEND) begin
              nxt[i].st  = ST_DONE;
              nxt[i].err = rsp_error;
            end
          end
        end
        if (!hit) m_unexp = 1'b1;
      end
      if (TO_EN)
        for (int i = 0; i < OUT; i++)
          if (nxt[i].v && nxt[i].st == ST_PEND && edge_n - nxt[i].acc >= TO) nxt[i].st = ST_EXP;
      if (di >= 0) nxt[di] = '{default: 0};
      if (acc) begin
        placed = 1'b0;
        for (int i = 0; i < OUT; i++) begin
          if (!m[i].v && !placed) begin
            nxt[i] = '{v: 1'b1, aggr: bar_aggr, id: bar_id, st: ST_PEND, err: 1'b0, acc: edge_n};
            placed = 1'b1;
          end
        end
        exp_q.push_back({bar_aggr, bar_id});
      end
      m = nxt;
    end
    edge_n++;
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic drive_bar(input bit v, input int a, input int id);
    bar_valid = v;
    bar_aggr  = AW'(a);
    bar_id    = IW'(id);
  endtask

  task automatic drive_rsp(input bit w, input int a, input int id, input bit e);
    rsp_wake  = w;
    rsp_aggr  = AW'(a);
    rsp_id    = IW'(id);
    rsp_error = e;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive_bar(0, 0, 0);
    drive_rsp(0, 0, 0, 0);
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int j;
    rst = 1'b1;
    drive_bar(0, 0, 0);
    drive_rsp(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset(1);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_unexpected", 32'(unexpected), 32'(0));

    // Single barrier
    drive_bar(1, 1, 0); tick(); drive_bar(0, 0, 0);
    check("s1_req_sync", 32'(req_sync), 32'(1));
    check("s1_req_src", 32'(req_src), 32'(SRC));
    tick();
    check("s1_req_once", 32'(req_sync), 32'(0));
    repeat (WAKE_AT - 2) tick();
    drive_rsp(1, 1, 0, 0); tick(); drive_rsp(0, 0, 0, 0);
    check("s1_done", 32'({done, done_aggr, done_id, done_error}), 32'({1'b1, 1'b1, 2'd0, 1'b0}));
    tick();
    check("s1_busy", 32'(busy), 32'(0));
    do_reset(2);

    // Full table
    drive_bar(1, 0, 0); tick(); drive_bar(0, 0, 0); tick();
    drive_bar(1, 0, 1); tick(); drive_bar(1, 0, 2); tick();
    check("s2_full_stall", 32'(bar_ready), 32'(0));
    tick();
    drive_rsp(1, 0, 1, 0); tick(); drive_rsp(0, 0, 0, 0);
    check("s2_done_id1", 32'({done, done_id}), 32'({1'b1, 2'd1}));
    check("s2_still_full", 32'(bar_ready), 32'(0));
    tick();
    check("s2_slot_free", 32'(bar_ready), 32'(1));
    tick(); drive_bar(0, 0, 0);
    check("s2_req_id2", 32'({req_sync, req_id}), 32'({1'b1, 2'd2}));
    drive_rsp(1, 0, 0, 0); tick();
    drive_rsp(1, 0, 2, 0); tick(); drive_rsp(0, 0, 0, 0);
    repeat (3) tick();
    do_reset(2);

    // Duplicate stalls until the original frees
    drive_bar(1, 0, 0); tick(); drive_bar(0, 0, 0); tick();
    drive_bar(1, 0, 0); tick();
    check("s3_dup_stall", 32'(bar_ready), 32'(0));
    tick(); tick();
    drive_rsp(1, 0, 0, 0); tick(); drive_rsp(0, 0, 0, 0);
    check("s3_done", 32'({done, done_id}), 32'({1'b1, 2'd0}));
    tick();
    check("s3_dup_ready", 32'(bar_ready), 32'(1));
    tick(); drive_bar(0, 0, 0);
    check("s3_reissue", 32'({req_sync, req_id}), 32'({1'b1, 2'd0}));
    drive_rsp(1, 0, 0, 0); tick(); drive_rsp(0, 0, 0, 0);
    repeat (2) tick();
    do_reset(2);

    // Out-of-order completion with error
    drive_bar(1, 0, 0); tick(); drive_bar(0, 0, 0); tick();
    drive_bar(1, 0, 1); tick(); drive_bar(0, 0, 0); tick();
    drive_rsp(1, 0, 1, 1); tick(); drive_rsp(1, 0, 0, 0);
    check("s4_first", 32'({done, done_id, done_error}), 32'({1'b1, 2'd1, 1'b1}));
    tick(); drive_rsp(0, 0, 0, 0);
    check("s4_second", 32'({done, done_id, done_error}), 32'({1'b1, 2'd0, 1'b0}));
    tick();
    check("s4_idle", 32'({done, busy}), 32'(0));
    do_reset(2);

    // Unexpected wake, sticky until reset; wake in the accept cycle is also unmatched
    drive_rsp(1, 0, 3, 0); tick(); drive_rsp(0, 0, 0, 0);
    check("s5_unexpected", 32'({unexpected, done}), 32'({1'b1, 1'b0}));
    drive_bar(1, 0, 1); drive_rsp(1, 0, 1, 0); tick(); drive_bar(0, 0, 0);
    tick(); drive_rsp(0, 0, 0, 0);
    repeat (4) tick();
    check("s5_sticky", 32'(unexpected), 32'(1));
    do_reset(1);
    check("s5_cleared", 32'(unexpected), 32'(0));

    // Expiry
    drive_bar(1, 0, 0); tick(); drive_bar(0, 0, 0);
    repeat (8) tick();
`ifdef FRACTAL_SYNC_INITIATOR_TIMEOUT_EN
    check("s6_timeout", 32'({done, done_timeout, done_error}), 32'(3'b111));
`else
    check("s6_waits", 32'({done, busy}), 32'(2'b01));
`endif
    tick();
    drive_rsp(1, 0, 0, 0); tick(); drive_rsp(0, 0, 0, 0);
    check("s6_late_wake", 32'(unexpected), 32'(TO_EN));
    repeat (2) tick();
    do_reset(2);

    // Random traffic with occasional mid-operation reset
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive_bar($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      j = $urandom_range(0, OUT - 1);
      if (m[j].v && $urandom_range(0, 4) != 0)
        drive_rsp($urandom_range(0, 2) == 0, m[j].aggr, m[j].id, $urandom_range(0, 1));
      else
        drive_rsp($urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1));
      tick();
    end
    do_reset(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
